// File: rtl/pal_cfg_loader_if.sv
// Handshake and status bundle between a configuration source and pal_cfg_loader.
// master: drives START/ABORT and the word stream, observes loader status and PAL pins.
// slave : the loader itself; accepts words, drives PAL_CLK/PAL_CFG and status.
interface pal_cfg_loader_if #(
  parameter int N = 4,
  parameter int M = 1,
  parameter int P = 3,
  parameter int W = 8
);
  localparam int L   = 2*N*P + P*M;
  localparam int BCW = $clog2(L+1);

  logic           START;
  logic           ABORT;
  logic [W-1:0]   WORD_DATA;
  logic           WORD_VALID;
  logic           WORD_READY;
  logic           PAL_CLK;
  logic           PAL_CFG;
  logic           BUSY;
  logic           DONE;
  logic [BCW-1:0] BIT_COUNT;

  modport master (
    output START, ABORT, WORD_DATA, WORD_VALID,
    input  WORD_READY, PAL_CLK, PAL_CFG, BUSY, DONE, BIT_COUNT
  );

  modport slave (
    input  START, ABORT, WORD_DATA, WORD_VALID,
    output WORD_READY, PAL_CLK, PAL_CFG, BUSY, DONE, BIT_COUNT
  );
endinterface

// File: rtl/pal_cfg_loader.sv
// Serialises an L-bit PAL configuration bitstream, fetched as W-bit words, onto PAL_CFG/PAL_CLK.
// Latency: one FETCH cycle per word plus two cycles (SETUP, PULSE) per bit; every output is a flop.
// Backpressure: WORD_READY is high only in FETCH; the loader waits there indefinitely for WORD_VALID.
//
// Ports:
//   CLK, RST_N            : clock, asynchronous active-low reset
//   bus.START / bus.ABORT : begin a load (ignored while busy) / cancel a load (wins over everything)
//   bus.WORD_DATA/VALID   : next bitstream word, LSB shifted out first
//   bus.WORD_READY        : word accepted on this cycle's rising edge when VALID is also high
//   bus.PAL_CLK/PAL_CFG   : serial shift clock and data to the PAL
//   bus.BUSY/DONE         : load in progress / last load completed with all L bits
//   bus.BIT_COUNT         : bits shifted in the current or most recent load
module pal_cfg_loader #(
  parameter int N = 4,
  parameter int M = 1,
  parameter int P = 3,
  parameter int W = 8
) (
  input logic              CLK,
  input logic              RST_N,
  pal_cfg_loader_if.slave  bus
);

  localparam int L        = 2*N*P + P*M;
  localparam int NW       = (L + W - 1) / W;
  localparam int BCW      = $clog2(L+1);
  localparam int IW       = (W > 1) ? $clog2(W) : 1;
  localparam int WCW      = $clog2(NW+1);
  // In-word index of the final real bit inside the last word; bits above it are padding.
  localparam int LAST_IDX = L - (NW-1)*W - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SETUP = 2'd2,
    S_PULSE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_nxt_state;
  logic [W-1:0]    r_shift;
  logic [W-1:0]    w_nxt_shift;
  logic [W-1:0]    w_shifted;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_nxt_idx;
  logic [WCW-1:0]  r_word_cnt;
  logic [WCW-1:0]  w_nxt_word_cnt;
  logic [BCW-1:0]  r_bit_count;
  logic [BCW-1:0]  w_nxt_bit_count;
  logic            r_pal_cfg;
  logic            w_nxt_pal_cfg;
  logic            r_done;
  logic            w_nxt_done;
  logic            r_pal_clk;
  logic            r_word_ready;
  logic            r_busy;
  logic            w_accept;
  logic            w_abort;
  logic            w_last_bit;

  assign w_shifted  = r_shift >> 1;
  assign w_accept   = (r_state == S_FETCH) && r_word_ready && bus.WORD_VALID;
  assign w_abort    = bus.ABORT && (r_state != S_IDLE);
  // The final bit is reached in the last word at LAST_IDX; this ends the load before any
  // padding bit of the last word is presented, so padding never produces a PAL_CLK pulse.
  assign w_last_bit = (r_word_cnt == WCW'(NW)) && (r_idx == IW'(LAST_IDX));

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_shift     = r_shift;
    w_nxt_idx       = r_idx;
    w_nxt_word_cnt  = r_word_cnt;
    w_nxt_bit_count = r_bit_count;
    w_nxt_pal_cfg   = r_pal_cfg;
    w_nxt_done      = r_done;

    if (w_abort) begin
      // A word handshaking in the same cycle is dropped: the shift register is not loaded.
      w_nxt_state = S_IDLE;
      w_nxt_done  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.START) begin
            w_nxt_state     = S_FETCH;
            w_nxt_done      = 1'b0;
            w_nxt_bit_count = '0;
            w_nxt_word_cnt  = '0;
          end
        end

        S_FETCH: begin
          if (w_accept) begin
            w_nxt_shift    = bus.WORD_DATA;
            w_nxt_idx      = '0;
            w_nxt_word_cnt = r_word_cnt + WCW'(1);
            w_nxt_pal_cfg  = bus.WORD_DATA[0];
            w_nxt_state    = S_SETUP;
          end
        end

        S_SETUP: begin
          w_nxt_state     = S_PULSE;
          w_nxt_bit_count = r_bit_count + BCW'(1);
        end

        S_PULSE: begin
          if (w_last_bit) begin
            w_nxt_state = S_IDLE;
            w_nxt_done  = 1'b1;
          end else if (r_idx == IW'(W-1)) begin
            w_nxt_state = S_FETCH;
          end else begin
            w_nxt_shift   = w_shifted;
            w_nxt_idx     = r_idx + IW'(1);
            w_nxt_pal_cfg = w_shifted[0];
            w_nxt_state   = S_SETUP;
          end
        end

        default: begin
          w_nxt_state = S_IDLE;
        end
      endcase
    end
  end

  // PAL_CLK, WORD_READY and BUSY are decoded from the next state and registered, so the
  // pins change only on CLK edges and PAL_CLK cannot glitch.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_idx        <= '0;
      r_word_cnt   <= '0;
      r_bit_count  <= '0;
      r_pal_cfg    <= 1'b0;
      r_done       <= 1'b0;
      r_pal_clk    <= 1'b0;
      r_word_ready <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_shift      <= w_nxt_shift;
      r_idx        <= w_nxt_idx;
      r_word_cnt   <= w_nxt_word_cnt;
      r_bit_count  <= w_nxt_bit_count;
      r_pal_cfg    <= w_nxt_pal_cfg;
      r_done       <= w_nxt_done;
      r_pal_clk    <= (w_nxt_state == S_PULSE);
      r_word_ready <= (w_nxt_state == S_FETCH);
      r_busy       <= (w_nxt_state != S_IDLE);
    end
  end

  assign bus.WORD_READY = r_word_ready;
  assign bus.PAL_CLK    = r_pal_clk;
  assign bus.PAL_CFG    = r_pal_cfg;
  assign bus.BUSY       = r_busy;
  assign bus.DONE       = r_done;
  assign bus.BIT_COUNT  = r_bit_count;

endmodule
